// File: rtl/des_key_scheduler.sv
// DES key schedule: holds the C/D halves and rotates them per round, offering one
// 48-bit subkey at a time over a valid/ready handshake in encrypt or decrypt order.
module des_key_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    input  logic        subkey_ready,
    output logic        subkey_valid,
    output logic [47:0] subkey,
    output logic [3:0]  round,
    output logic        busy,
    output logic        done
);

    // FIPS bit n of a vector maps to index (width - n).
    localparam int Pc1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int Pc2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [27:0] c_q, c_d, dh_q, dh_d;
    logic [3:0]  round_q, round_d;
    logic        dec_q, dec_d;
    logic        done_q, done_d;
    logic [55:0] loaded;
    logic [3:0]  next_round;
    logic        single;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = k[6'(64 - Pc1[i])];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 48; j++) begin
            r[6'(47 - j)] = cd[6'(56 - Pc2[j])];
        end
        return r;
    endfunction

    function automatic logic [27:0] rot(input logic [27:0] x, input logic left,
                                        input logic one);
        logic [27:0] r;
        case ({left, one})
            2'b11:   r = {x[26:0], x[27]};
            2'b10:   r = {x[25:0], x[27:26]};
            2'b01:   r = {x[0], x[27:1]};
            default: r = {x[1:0], x[27:2]};
        endcase
        return r;
    endfunction

    assign loaded     = pc1(key_in);
    assign next_round = round_q + 4'd1;
    // Encrypt shift s(r+1) and the decrypt undo-shift are both single-step at rounds 1, 8, 15.
    assign single     = (next_round == 4'd1) || (next_round == 4'd8) || (next_round == 4'd15);

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        dh_d    = dh_q;
        round_d = round_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    dec_d   = decrypt;
                    round_d = 4'd0;
                    state_d = StRun;
                    if (decrypt) begin
                        c_d  = loaded[55:28];
                        dh_d = loaded[27:0];
                    end else begin
                        c_d  = rot(loaded[55:28], 1'b1, 1'b1);
                        dh_d = rot(loaded[27:0], 1'b1, 1'b1);
                    end
                end
            end
            StRun: begin
                if (subkey_ready) begin
                    if (round_q == 4'd15) begin
                        state_d = StIdle;
                        round_d = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        round_d = next_round;
                        c_d     = rot(c_q, !dec_q, single);
                        dh_d    = rot(dh_q, !dec_q, single);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            c_q     <= '0;
            dh_q    <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            dh_q    <= dh_d;
            round_q <= round_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

    assign subkey_valid = (state_q == StRun);
    assign busy         = (state_q == StRun);
    assign subkey       = pc2({c_q, dh_q});
    assign round        = round_q;
    assign done         = done_q;

endmodule

// File: tb/tb_des_key_scheduler.sv
// Bench for des_key_scheduler: directed runs with random backpressure, checked against a
// table-driven model that derives each round's subkey from the key and the cumulative shift.
module tb_des_key_scheduler;

    localparam int Pc1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int Pc2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int Shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] Key = 64'h133457799BBCDFF1;
    localparam logic [47:0] K1  = 48'h1B02EFFC7072;
    localparam logic [47:0] K2  = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        decrypt;
    logic [63:0] key_in;
    logic        subkey_ready;
    logic        subkey_valid;
    logic [47:0] subkey;
    logic [3:0]  round;
    logic        busy;
    logic        done;

    int          vectors = 0;
    int          miscompares = 0;
    logic [47:0] got [16];
    logic [47:0] enc [16];
    int          cycles;

    des_key_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .decrypt      (decrypt),
        .key_in       (key_in),
        .subkey_ready (subkey_ready),
        .subkey_valid (subkey_valid),
        .subkey       (subkey),
        .round        (round),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Subkey for FIPS round k (1..16): PC-2 of PC-1 halves left-rotated by the cumulative shift.
    function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int k);
        int          sh;
        int          p;
        int          src;
        logic [47:0] r;
        sh = 0;
        r  = '0;
        for (int i = 0; i < k; i++) sh += Shifts[i];
        for (int j = 1; j <= 48; j++) begin
            p = Pc2[j - 1];
            if (p <= 28) src = Pc1[(p - 1 + sh) % 28];
            else         src = Pc1[28 + (p - 29 + sh) % 28];
            r[48 - j] = key[64 - src];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [63:0] key, input logic dec);
        start   = 1'b1;
        key_in  = key;
        decrypt = dec;
        @(posedge clk); #1;
        start   = 1'b0;
        key_in  = {$urandom, $urandom};
        decrypt = ~dec;
    endtask

    // Consume all sixteen subkeys; returns at the cycle right after the final handshake.
    task automatic drain(input logic [63:0] key, input logic dec, input int pct,
                         input bit poke, output int cyc);
        int idx;
        bit poked;
        idx   = 0;
        cyc   = 0;
        poked = 0;
        while (idx < 16 && cyc < 600) begin
            check("valid", 64'(subkey_valid), 64'd1);
            check("busy", 64'(busy), 64'd1);
            check("done_low", 64'(done), 64'd0);
            check("round", 64'(round), 64'(idx));
            check($sformatf("subkey_r%0d", idx), 64'(subkey),
                  64'(ref_subkey(key, dec ? 16 - idx : idx + 1)));
            got[idx] = subkey;
            if (poke && idx == 5 && !poked) begin
                start   = 1'b1;
                key_in  = ~key;
                decrypt = ~dec;
                poked   = 1;
            end
            subkey_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            @(posedge clk); #1;
            start = 1'b0;
            if (subkey_ready) idx++;
            cyc++;
        end
        subkey_ready = 1'b0;
        if (idx < 16) check("timeout", 64'(idx), 64'd16);
        check("done_pulse", 64'(done), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
        check("valid_after", 64'(subkey_valid), 64'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        decrypt      = 1'b0;
        key_in       = '0;
        subkey_ready = 1'b0;
        #12;
        check("rst_valid", 64'(subkey_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_subkey", 64'(subkey), 64'd0);
        check("rst_round", 64'(round), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Encrypt, ready held high
        do_start(Key, 1'b0);
        check("enc_k1_first", 64'(subkey), 64'(K1));
        drain(Key, 1'b0, 100, 0, cycles);
        check("enc_cycles", 64'(cycles), 64'd16);
        check("enc_r1", 64'(got[1]), 64'(K2));
        check("enc_r15", 64'(got[15]), 64'(K16));
        for (int i = 0; i < 16; i++) enc[i] = got[i];
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'd0);

        // Decrypt: reversed order
        do_start(Key, 1'b1);
        drain(Key, 1'b1, 100, 0, cycles);
        check("dec_r0", 64'(got[0]), 64'(K16));
        check("dec_r14", 64'(got[14]), 64'(K2));
        check("dec_r15", 64'(got[15]), 64'(K1));
        for (int i = 0; i < 16; i++)
            check($sformatf("dec_rev%0d", i), 64'(got[i]), 64'(enc[15 - i]));
        @(posedge clk); #1;

        // Backpressure at ~30% ready
        do_start(Key, 1'b0);
        drain(Key, 1'b0, 30, 0, cycles);
        for (int i = 0; i < 16; i++)
            check($sformatf("bp_seq%0d", i), 64'(got[i]), 64'(enc[i]));
        @(posedge clk); #1;

        // Parity-only key change, plus a stray start at round 5
        do_start(Key ^ 64'h0101010101010101, 1'b0);
        drain(Key, 1'b0, 100, 1, cycles);
        for (int i = 0; i < 16; i++)
            check($sformatf("par_seq%0d", i), 64'(got[i]), 64'(enc[i]));
        @(posedge clk); #1;

        // Reset mid-run at round 7
        do_start(Key, 1'b0);
        subkey_ready = 1'b1;
        repeat (7) begin
            @(posedge clk); #1;
        end
        check("pre_rst_round", 64'(round), 64'd7);
        subkey_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(subkey_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_subkey", 64'(subkey), 64'd0);
        check("mid_rst_round", 64'(round), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_done", 64'(done), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        do_start(Key, 1'b0);
        check("restart_k1", 64'(subkey), 64'(K1));
        drain(Key, 1'b0, 100, 0, cycles);

        // Back-to-back: start in the done cycle
        do_start(Key, 1'b1);
        check("b2b_valid", 64'(subkey_valid), 64'd1);
        check("b2b_k16", 64'(subkey), 64'(K16));
        check("b2b_done_low", 64'(done), 64'd0);
        drain(Key, 1'b1, 100, 0, cycles);
        @(posedge clk); #1;
        check("final_done_low", 64'(done), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/des_key_scheduler.md
# des_key_scheduler

Sequential DES key-schedule controller that turns one 64-bit key into the sixteen 48-bit round subkeys, one per round, in encrypt (K1..K16) or decrypt (K16..K1) order. It holds the 28-bit C/D halves in registers and sequences the left/right rotations. Subkeys go out over a valid/ready handshake, so the DES round datapath can consume them at its own pace. It sits between the key-load path and the round engine and replaces any fixed combinational rotation chain.

## Interface
- No parameters.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a new schedule; accepted only in IDLE.
- `decrypt` input 1: sampled with `start`; 0 = encrypt order, 1 = decrypt order.
- `key_in` input [1:64]: DES key, FIPS 46-3 bit numbering (bit 1 = MSB); sampled with `start`.
- `subkey_ready` input 1: consumer accepts the current subkey.
- `subkey_valid` output 1: `subkey` and `round` are valid.
- `subkey` output [1:48]: PC-2 of the current C/D registers.
- `round` output [3:0]: 0-based index of the subkey being offered.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse after the last subkey is accepted.

## Operation
- The PC-1, PC-2 and shift schedule follow FIPS 46-3 exactly. Parity bits 8,16,…,64 are ignored.
- Shift amount s(i) for 0-based encrypt index i is 1 for i ∈ {0,1,8,15} and 2 otherwise. The sum of all sixteen shifts is 28, which is the identity rotation.
- There are two states, IDLE and RUN.
- In IDLE with `start`=1:
  - For encrypt, load C/D ← rotl(PC-1(key_in), 1).
  - For decrypt, load C/D ← PC-1(key_in) with no rotation.
  - Latch `decrypt`, set `round` to 0 and go to RUN.
- In RUN, a handshake is `subkey_valid & subkey_ready`.
- On a handshake with `round` < 15, `round` increments to r+1 and C/D rotate:
  - Encrypt: rotl by s(r+1), applied to both halves independently.
  - Decrypt: rotr by 1 if r+1 ∈ {1,8,15}, otherwise rotr by 2.
- On a handshake with `round` = 15: go to IDLE, clear `round` to 0, and assert `done` for the next cycle.
- With no handshake, the state, C/D and `round` hold, and `subkey` stays stable.
- Encrypt offers K1..K16 at `round` 0..15. Decrypt offers K16..K1 at `round` 0..15.
- `start` while in RUN is ignored. Changes to `key_in` or `decrypt` during RUN have no effect.
- `start` in the cycle where `done`=1 is accepted, because the block is already in IDLE.

## Timing
- Reset values: state IDLE, C/D = 0, `round` = 0, `subkey_valid` = 0, `busy` = 0, `done` = 0, `subkey` = 0.
- Reset asserted mid-run returns the block to IDLE immediately and drops `subkey_valid` and `busy` asynchronously. No `done` is generated.
- `subkey_valid` and `busy` equal (state == RUN). Both rise in the cycle after the `start` edge.
- First-subkey latency: 1 cycle from the `start` accept edge.
- With `subkey_ready` tied high:
  - One subkey is offered per cycle for 16 cycles.
  - `done` is high in cycle 17 after the accept edge, and `busy` is low in that same cycle.
- `subkey` depends combinationally only on the C/D registers (PC-2 is wiring), with no path from the inputs.
- `done` is registered and lasts exactly one cycle.

## Test plan
- **Encrypt, key 133457799BBCDFF1, ready=1:**
  - round 0 subkey = 1B02EFFC7072
  - round 1 = 79AED9DBC9E5
  - round 15 = CB3D8B0E17F5
  - `done` in cycle 17
- **Decrypt, same key, ready=1:**
  - round 0 = CB3D8B0E17F5
  - round 14 = 79AED9DBC9E5
  - round 15 = 1B02EFFC7072
  - All sixteen subkeys match the encrypt sequence reversed.
- **Backpressure:** encrypt with `subkey_ready` random 30% high. Each subkey is held stable while not accepted, `round` advances only on handshakes, and the sequence is identical to the ready=1 run.
- **Parity and start-ignore:** a key differing only in the parity bits (e.g. 123456789ABCDEF0 vs 133457799BBCDFF1 toggled at bits 8,16,…) yields identical subkeys. A `start` with a different key at round 5 changes nothing.
- **Reset mid-run:**
  - Assert `rst_n`=0 at round 7. Outputs go to 0 immediately and no `done` is produced.
  - A restart after release produces round 0 = 1B02EFFC7072.
- **Back-to-back:** `start` asserted in the `done` cycle with `decrypt`=1. The first subkey of the new decrypt run (CB3D8B0E17F5) is valid on the next cycle.
